// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder sitting between fetch and execute.
// Decodes all base formats, sign-extends immediates to XLEN, flags illegal
// encodings and holds the decoded bundle behind a valid/ready register with
// flush support. Every out_* signal is driven straight from a flop.
module decode_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic [XLEN-1:0]   out_imm,
    output logic [3:0]        out_alu_op,
    output logic              out_sel_a,
    output logic              out_sel_b,
    output logic              out_reg_wr,
    output logic              out_mem_wr,
    output logic              out_mem_rd,
    output logic [1:0]        out_wb_sel,
    output logic [2:0]        out_rd_wr_mem,
    output logic              out_branch,
    output logic              out_jump,
    output logic              out_illegal
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_PASS_B = 4'b1111
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   imm;
        logic [3:0]        alu_op;
        logic              sel_a;
        logic              sel_b;
        logic              reg_wr;
        logic              mem_wr;
        logic              mem_rd;
        wb_sel_e           wb_sel;
        logic [2:0]        funct3;
        logic              branch;
        logic              jump;
        logic              illegal;
    } bundle_t;

    // Instruction fields
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    bundle_t dec;
    bundle_t bundle_q, bundle_d;
    logic    valid_q, valid_d;
    logic    load;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign imm_i = XLEN'($signed(in_instr[31:20]));
    assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0}));

    // Combinational decode of the incoming instruction into a bundle
    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.rs1     = REG_AW'(in_instr[19:15]);
        dec.rs2     = REG_AW'(in_instr[24:20]);
        dec.rd      = REG_AW'(in_instr[11:7]);
        dec.funct3  = funct3;
        dec.alu_op  = ALU_ADD;
        dec.wb_sel  = WB_ALU;

        case (opcode)
            OPC_OP: begin
                dec.alu_op  = {funct3, in_instr[30]};
                dec.reg_wr  = 1'b1;
                dec.illegal = !((funct7 == 7'b0000000) ||
                                ((funct7 == 7'b0100000) &&
                                 ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_OPIMM: begin
                dec.imm     = imm_i;
                dec.sel_b   = 1'b1;
                dec.alu_op  = {funct3, (funct3 == 3'b101) ? in_instr[30] : 1'b0};
                dec.reg_wr  = 1'b1;
                if (funct3 == 3'b001)
                    dec.illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    dec.illegal = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
            end
            OPC_LOAD: begin
                dec.imm     = imm_i;
                dec.sel_b   = 1'b1;
                dec.mem_rd  = 1'b1;
                dec.wb_sel  = WB_MEM;
                dec.reg_wr  = 1'b1;
                dec.illegal = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                              (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec.imm     = imm_s;
                dec.sel_b   = 1'b1;
                dec.mem_wr  = 1'b1;
                dec.illegal = (funct3 > 3'b010);
            end
            OPC_BRANCH: begin
                dec.imm     = imm_b;
                dec.sel_a   = 1'b1;
                dec.sel_b   = 1'b1;
                dec.branch  = 1'b1;
                dec.illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LUI: begin
                dec.imm     = imm_u;
                dec.sel_b   = 1'b1;
                dec.alu_op  = ALU_PASS_B;
                dec.reg_wr  = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm     = imm_u;
                dec.sel_a   = 1'b1;
                dec.sel_b   = 1'b1;
                dec.reg_wr  = 1'b1;
            end
            OPC_JAL: begin
                dec.imm     = imm_j;
                dec.sel_a   = 1'b1;
                dec.sel_b   = 1'b1;
                dec.jump    = 1'b1;
                dec.wb_sel  = WB_PC4;
                dec.reg_wr  = 1'b1;
            end
            OPC_JALR: begin
                dec.imm     = imm_i;
                dec.sel_b   = 1'b1;
                dec.jump    = 1'b1;
                dec.wb_sel  = WB_PC4;
                dec.reg_wr  = 1'b1;
                dec.illegal = (funct3 != 3'b000);
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase

        // An illegal bundle still travels down the pipe but must not
        // change architectural state.
        if (dec.illegal) begin
            dec.reg_wr = 1'b0;
            dec.mem_wr = 1'b0;
            dec.mem_rd = 1'b0;
            dec.branch = 1'b0;
            dec.jump   = 1'b0;
        end
        if (in_instr[11:7] == 5'd0)
            dec.reg_wr = 1'b0;
    end

    // Handshake and next-state selection for the pipeline register
    always_comb begin
        in_ready = !valid_q || out_ready;
        load     = in_valid && in_ready && !flush;
        if (flush)
            valid_d = 1'b0;
        else if (in_ready)
            valid_d = in_valid;
        else
            valid_d = valid_q;
        bundle_d = load ? dec : bundle_q;
    end

    // Pipeline register, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = bundle_q.pc;
    assign out_rs1       = bundle_q.rs1;
    assign out_rs2       = bundle_q.rs2;
    assign out_rd        = bundle_q.rd;
    assign out_imm       = bundle_q.imm;
    assign out_alu_op    = bundle_q.alu_op;
    assign out_sel_a     = bundle_q.sel_a;
    assign out_sel_b     = bundle_q.sel_b;
    assign out_reg_wr    = bundle_q.reg_wr;
    assign out_mem_wr    = bundle_q.mem_wr;
    assign out_mem_rd    = bundle_q.mem_rd;
    assign out_wb_sel    = bundle_q.wb_sel;
    assign out_rd_wr_mem = bundle_q.funct3;
    assign out_branch    = bundle_q.branch;
    assign out_jump      = bundle_q.jump;
    assign out_illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector bench for decode_stage with hand-computed
// expected values for each RV32I format, stall, flush and reset behaviour.
module tb_decode_stage;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [REG_AW-1:0] out_rs1;
    logic [REG_AW-1:0] out_rs2;
    logic [REG_AW-1:0] out_rd;
    logic [XLEN-1:0]   out_imm;
    logic [3:0]        out_alu_op;
    logic              out_sel_a;
    logic              out_sel_b;
    logic              out_reg_wr;
    logic              out_mem_wr;
    logic              out_mem_rd;
    logic [1:0]        out_wb_sel;
    logic [2:0]        out_rd_wr_mem;
    logic              out_branch;
    logic              out_jump;
    logic              out_illegal;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    decode_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd        (out_rd),
        .out_imm       (out_imm),
        .out_alu_op    (out_alu_op),
        .out_sel_a     (out_sel_a),
        .out_sel_b     (out_sel_b),
        .out_reg_wr    (out_reg_wr),
        .out_mem_wr    (out_mem_wr),
        .out_mem_rd    (out_mem_rd),
        .out_wb_sel    (out_wb_sel),
        .out_rd_wr_mem (out_rd_wr_mem),
        .out_branch    (out_branch),
        .out_jump      (out_jump),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_pc",      out_pc, 32'h0);
        check("rst_imm",     out_imm, 32'h0);
        check("rst_reg_wr",  32'(out_reg_wr), 32'd0);
        check("rst_illegal", 32'(out_illegal), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        step();
        step();
        rst = 1'b0;
        step();

        // add x3,x1,x2
        present(32'h002081B3, 32'h0000_0000);
        check("add_valid",  32'(out_valid), 32'd1);
        check("add_rs1",    32'(out_rs1), 32'd1);
        check("add_rs2",    32'(out_rs2), 32'd2);
        check("add_rd",     32'(out_rd), 32'd3);
        check("add_alu",    32'(out_alu_op), 32'h0);
        check("add_reg_wr", 32'(out_reg_wr), 32'd1);
        check("add_sel_b",  32'(out_sel_b), 32'd0);
        check("add_wb",     32'(out_wb_sel), 32'd0);
        check("add_imm",    out_imm, 32'h0);

        // lw x5,-4(x2)
        present(32'hFFC12283, 32'h0000_0004);
        check("lw_imm",    out_imm, 32'hFFFF_FFFC);
        check("lw_mem_rd", 32'(out_mem_rd), 32'd1);
        check("lw_wb",     32'(out_wb_sel), 32'd1);
        check("lw_f3",     32'(out_rd_wr_mem), 32'd2);
        check("lw_sel_b",  32'(out_sel_b), 32'd1);
        check("lw_reg_wr", 32'(out_reg_wr), 32'd1);

        // sw x6,8(x1)
        present(32'h0060A423, 32'h0000_0008);
        check("sw_imm",    out_imm, 32'h8);
        check("sw_rs1",    32'(out_rs1), 32'd1);
        check("sw_rs2",    32'(out_rs2), 32'd6);
        check("sw_mem_wr", 32'(out_mem_wr), 32'd1);
        check("sw_reg_wr", 32'(out_reg_wr), 32'd0);

        // jal x1,+16 at pc 0x100
        present(32'h010000EF, 32'h0000_0100);
        check("jal_imm",    out_imm, 32'h10);
        check("jal_jump",   32'(out_jump), 32'd1);
        check("jal_sel_a",  32'(out_sel_a), 32'd1);
        check("jal_wb",     32'(out_wb_sel), 32'd2);
        check("jal_pc",     out_pc, 32'h100);
        check("jal_reg_wr", 32'(out_reg_wr), 32'd1);

        // srai x1,x2,3
        present(32'h40315093, 32'h0000_0104);
        check("srai_alu",     32'(out_alu_op), 32'hB);
        check("srai_imm",     out_imm, 32'h0000_0403);
        check("srai_illegal", 32'(out_illegal), 32'd0);

        // lui x7,0x12345
        present(32'h123453B7, 32'h0000_0108);
        check("lui_imm", out_imm, 32'h1234_5000);
        check("lui_alu", 32'(out_alu_op), 32'hF);
        check("lui_sel_a", 32'(out_sel_a), 32'd0);

        // auipc x4,0x1
        present(32'h00001217, 32'h0000_0200);
        check("auipc_imm",   out_imm, 32'h0000_1000);
        check("auipc_sel_a", 32'(out_sel_a), 32'd1);
        check("auipc_reg_wr", 32'(out_reg_wr), 32'd1);

        // beq x1,x2,-8
        present(32'hFE208CE3, 32'h0000_0204);
        check("beq_imm",    out_imm, 32'hFFFF_FFF8);
        check("beq_branch", 32'(out_branch), 32'd1);
        check("beq_sel_a",  32'(out_sel_a), 32'd1);
        check("beq_reg_wr", 32'(out_reg_wr), 32'd0);

        // jalr x0,0(x1): rd==0 suppresses the write
        present(32'h00008067, 32'h0000_0208);
        check("ret_jump",   32'(out_jump), 32'd1);
        check("ret_reg_wr", 32'(out_reg_wr), 32'd0);
        check("ret_sel_a",  32'(out_sel_a), 32'd0);

        // add x0,x1,x2
        present(32'h00208033, 32'h0000_020C);
        check("addx0_reg_wr", 32'(out_reg_wr), 32'd0);

        // Illegal known-opcode encodings
        present(32'h402091B3, 32'h0000_0210);
        check("rbad_illegal", 32'(out_illegal), 32'd1);
        check("rbad_reg_wr",  32'(out_reg_wr), 32'd0);
        present(32'h40311093, 32'h0000_0214);
        check("slli_illegal", 32'(out_illegal), 32'd1);
        check("slli_reg_wr",  32'(out_reg_wr), 32'd0);
        present(32'hFFC13283, 32'h0000_0218);
        check("ld011_illegal", 32'(out_illegal), 32'd1);
        check("ld011_mem_rd",  32'(out_mem_rd), 32'd0);
        present(32'hFE20ACE3, 32'h0000_021C);
        check("br010_illegal", 32'(out_illegal), 32'd1);
        check("br010_branch",  32'(out_branch), 32'd0);

        // Stall: out_ready low for 3 cycles while fetch keeps offering lw
        present(32'h002081B3, 32'h0000_0010);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFC12283;
        in_pc     = 32'h0000_0014;
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid",    32'(out_valid), 32'd1);
            check("stall_rd",       32'(out_rd), 32'd3);
            check("stall_pc",       out_pc, 32'h10);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("release_rd",     32'(out_rd), 32'd5);
        check("release_pc",     out_pc, 32'h14);
        check("release_mem_rd", 32'(out_mem_rd), 32'd1);
        check("release_valid",  32'(out_valid), 32'd1);

        // Illegal word, then flush with an incoming instruction
        present(32'hFFFFFFFF, 32'h0000_0020);
        check("ill_valid",   32'(out_valid), 32'd1);
        check("ill_illegal", 32'(out_illegal), 32'd1);
        check("ill_reg_wr",  32'(out_reg_wr), 32'd0);
        check("ill_mem_wr",  32'(out_mem_wr), 32'd0);
        check("ill_jump",    32'(out_jump), 32'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        in_pc    = 32'h0000_0024;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_rd",    32'(out_rd), 32'd31);
        check("flush_pc",    out_pc, 32'h20);
        step();
        check("flush_valid2", 32'(out_valid), 32'd0);

        // Flush while a bundle is being held
        present(32'h002081B3, 32'h0000_0030);
        out_ready = 1'b0;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b1;
        check("hflush_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a stall
        present(32'hFFC12283, 32'h0000_0040);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0060A423;
        in_pc     = 32'h0000_0044;
        step();
        check("rstall_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstall_valid0", 32'(out_valid), 32'd0);
        check("rstall_rd",     32'(out_rd), 32'd0);
        check("rstall_pc",     out_pc, 32'h0);
        step();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        present(32'h0060A423, 32'h0000_0050);
        check("recover_mem_wr", 32'(out_mem_wr), 32'd1);
        check("recover_pc",     out_pc, 32'h50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
